// File: rtl/serial_byte_receiver.sv
// Asynchronous 8N1 serial receiver: deserialises RxD into bytes, LSB first.
// Latency: start edge on the pin to RxD_data_ready is about 9.5 bit periods + 3 clocks.
// No backpressure: ready and frame_error are single-clock pulses the consumer must catch.
module serial_byte_receiver #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 8,
  parameter int DIV        = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic       RxD_data_ready,
  output logic [7:0] RxD_data,
  output logic       RxD_frame_error,
  output logic       RxD_idle
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  // Synchroniser and sample timing
  logic             rx_m;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [OS_W-1:0]  tick_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Sample-point decodes (qualified by state in the output process)
  logic half_point;
  logic full_point;

  // Control strobes from the output process
  logic tick_run;
  logic clr_ticks;
  logic start_ok;
  logic take_bit;
  logic accept;
  logic frame_bad;

  assign tick       = tick_run && (div_cnt == DIV_LAST);
  assign half_point = tick && (tick_cnt == OS_HALF);
  assign full_point = tick && (tick_cnt == OS_LAST);

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RxD;
      rx_s <= rx_m;
    end
  end

  // Oversample tick divider, held at zero in IDLE so ticks align to the start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!tick_run || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Ticks elapsed within the current bit, restarted at each sample point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (clr_ticks) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + OS_W'(1);
    end
  end

  // Data shift register and bit index; LSB arrives first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else if (start_ok) begin
      bit_idx <= 3'd0;
    end else if (take_bit) begin
      shift[bit_idx] <= rx_s;
      bit_idx        <= bit_idx + 3'd1;
    end
  end

  // Output byte and single-clock status pulses, registered off the stop-bit sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RxD_data        <= 8'h00;
      RxD_data_ready  <= 1'b0;
      RxD_frame_error <= 1'b0;
    end else begin
      RxD_data_ready  <= accept;
      RxD_frame_error <= frame_bad;
      if (accept) begin
        RxD_data <= shift;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (!rx_s) next_state = S_START;
      end
      S_START: begin
        if (half_point) next_state = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (full_point && (bit_idx == 3'd7)) next_state = S_STOP;
      end
      S_STOP: begin
        if (full_point) next_state = rx_s ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (rx_s) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output / control decode from the current state
  always_comb begin
    tick_run  = 1'b1;
    clr_ticks = 1'b0;
    start_ok  = 1'b0;
    take_bit  = 1'b0;
    accept    = 1'b0;
    frame_bad = 1'b0;
    RxD_idle  = 1'b0;
    unique case (state)
      S_IDLE: begin
        tick_run  = 1'b0;
        clr_ticks = 1'b1;
        RxD_idle  = 1'b1;
      end
      S_START: begin
        if (half_point) begin
          clr_ticks = 1'b1;
          start_ok  = !rx_s;
        end
      end
      S_DATA: begin
        if (full_point) begin
          clr_ticks = 1'b1;
          take_bit  = 1'b1;
        end
      end
      S_STOP: begin
        if (full_point) begin
          clr_ticks = 1'b1;
          accept    = rx_s;
          frame_bad = !rx_s;
        end
      end
      S_BREAK: begin
        tick_run  = 1'b0;
        clr_ticks = 1'b1;
      end
      default: begin
        tick_run = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_byte_receiver.sv
module tb_serial_byte_receiver;

  localparam int BIT0 = 216;   // default build: 27 clocks/tick * 8 ticks/bit
  localparam int BIT1 = 2600;  // 9600 baud build: 325 * 8

  logic       clk;
  logic       rst_n;
  logic       rxd0, rxd1;
  logic       rdy0, rdy1;
  logic [7:0] data0, data1;
  logic       err0, err1;
  logic       idle0, idle1;

  serial_byte_receiver dut0 (
    .clk(clk), .rst_n(rst_n), .RxD(rxd0),
    .RxD_data_ready(rdy0), .RxD_data(data0),
    .RxD_frame_error(err0), .RxD_idle(idle0)
  );

  serial_byte_receiver #(.BAUD(9600)) dut1 (
    .clk(clk), .rst_n(rst_n), .RxD(rxd1),
    .RxD_data_ready(rdy1), .RxD_data(data1),
    .RxD_frame_error(err1), .RxD_idle(idle1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log: every received byte and every error pulse, sampled mid-cycle
  logic [7:0] rq0[$];
  int         rt0[$];
  logic [7:0] rq1[$];
  int         ecnt0 = 0, ecnt1 = 0, both_cnt = 0;
  int         t_start0 = 0;

  always @(negedge clk) begin
    if (rdy0) begin
      rq0.push_back(data0);
      rt0.push_back(cyc);
    end
    if (rdy1) rq1.push_back(data1);
    if (err0) ecnt0++;
    if (err1) ecnt1++;
    if ((rdy0 && err0) || (rdy1 && err1)) both_cnt++;
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input int inst, input logic v);
    if (inst == 0) rxd0 = v;
    else rxd1 = v;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; the caller is on a falling edge, the task leaves on one
  task automatic send_frame(input int inst, input logic [7:0] b, input int bitclk,
                            input logic stop_v, input int stop_len);
    if (inst == 0) t_start0 = cyc;
    drive(inst, 1'b0);
    wait_clk(bitclk);
    for (int i = 0; i < 8; i++) begin
      drive(inst, b[i]);
      wait_clk(bitclk);
    end
    drive(inst, stop_v);
    wait_clk(stop_len);
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] rb;
  logic [7:0] c3;
  int         e_before;
  int         lat;

  initial begin
    rxd0  = 1'b1;
    rxd1  = 1'b1;
    rst_n = 1'b0;
    wait_clk(5);

    // Reset values
    check("rst_data", 32'(data0), 32'h00);
    check("rst_ready", 32'(rdy0), 32'h0);
    check("rst_ferr", 32'(err0), 32'h0);
    check("rst_idle", 32'(idle0), 32'h1);
    rst_n = 1'b1;
    wait_clk(10);

    // Single frame 0x55 plus start-to-ready latency
    send_frame(0, 8'h55, BIT0, 1'b1, BIT0);
    wait_clk(20);
    check("b55_count", 32'(rq0.size()), 32'd1);
    if (rq0.size() > 0) check("b55_data", 32'(rq0[0]), 32'h55);
    lat = (rt0.size() > 0) ? rt0[0] - t_start0 : 0;
    check("b55_latency", 32'((lat >= 2050) && (lat <= 2060)), 32'h1);
    check("b55_ferr", 32'(ecnt0), 32'd0);

    // Back-to-back frames with no idle gap
    rq0 = {};
    rt0 = {};
    send_frame(0, 8'hA5, BIT0, 1'b1, BIT0);
    send_frame(0, 8'h00, BIT0, 1'b1, BIT0);
    send_frame(0, 8'hFF, BIT0, 1'b1, BIT0);
    wait_clk(20);
    check("b2b_count", 32'(rq0.size()), 32'd3);
    if (rq0.size() == 3) begin
      check("b2b_d0", 32'(rq0[0]), 32'hA5);
      check("b2b_d1", 32'(rq0[1]), 32'h00);
      check("b2b_d2", 32'(rq0[2]), 32'hFF);
      check("b2b_gap01", 32'((rt0[1] - rt0[0] >= 2158) && (rt0[1] - rt0[0] <= 2162)), 32'h1);
      check("b2b_gap12", 32'((rt0[2] - rt0[1] >= 2158) && (rt0[2] - rt0[1] <= 2162)), 32'h1);
    end

    // Short low glitch must be rejected as a false start
    rq0 = {};
    rxd0 = 1'b0;
    wait_clk(50);
    rxd0 = 1'b1;
    wait_clk(300);
    check("glitch_idle", 32'(idle0), 32'h1);
    check("glitch_ready", 32'(rq0.size()), 32'd0);
    check("glitch_ferr", 32'(ecnt0), 32'd0);
    check("glitch_data", 32'(data0), 32'hFF);

    // Stop bit low, line held low: one error, byte kept, stays out of IDLE
    send_frame(0, 8'h3C, BIT0, 1'b0, BIT0 + 1000);
    check("ferr_count", 32'(ecnt0), 32'd1);
    check("ferr_ready", 32'(rq0.size()), 32'd0);
    check("ferr_data", 32'(data0), 32'hFF);
    check("ferr_idle_low", 32'(idle0), 32'h0);
    rxd0 = 1'b1;
    wait_clk(10);
    check("ferr_idle_back", 32'(idle0), 32'h1);
    wait_clk(BIT0);
    send_frame(0, 8'h12, BIT0, 1'b1, BIT0);
    wait_clk(20);
    check("after_ferr_count", 32'(rq0.size()), 32'd1);
    check("after_ferr_data", 32'(data0), 32'h12);
    check("after_ferr_errs", 32'(ecnt0), 32'd1);

    // Reset in the middle of data bit 4 of 0xC3
    rq0 = {};
    c3 = 8'hC3;
    rxd0 = 1'b0;
    wait_clk(BIT0);
    for (int i = 0; i < 4; i++) begin
      rxd0 = c3[i];
      wait_clk(BIT0);
    end
    rxd0 = c3[4];
    wait_clk(BIT0 / 2);
    rst_n = 1'b0;
    wait_clk(5);
    check("midrst_data", 32'(data0), 32'h00);
    check("midrst_idle", 32'(idle0), 32'h1);
    rxd0 = 1'b1;
    rst_n = 1'b1;
    wait_clk(3 * BIT0);
    check("midrst_no_ready", 32'(rq0.size()), 32'd0);
    check("midrst_no_err", 32'(ecnt0), 32'd1);
    send_frame(0, 8'h7E, BIT0, 1'b1, BIT0);
    wait_clk(20);
    check("midrst_next_count", 32'(rq0.size()), 32'd1);
    check("midrst_next_data", 32'(data0), 32'h7E);

    // 9600 baud at +/-2% running alongside randomized traffic on the fast receiver
    rq0 = {};
    rq1 = {};
    exp_q = {};
    e_before = ecnt0;
    fork
      begin
        send_frame(1, 8'h81, 2548, 1'b1, 2548);
        wait_clk(200);
        send_frame(1, 8'h81, 2652, 1'b1, 2652);
        wait_clk(200);
      end
      begin
        for (int n = 0; n < 16; n++) begin
          rb = 8'($urandom_range(0, 255));
          exp_q.push_back(rb);
          send_frame(0, rb, BIT0, 1'b1, BIT0);
          wait_clk($urandom_range(0, 200));
        end
        wait_clk(20);
      end
    join
    check("slow_count", 32'(rq1.size()), 32'd2);
    if (rq1.size() == 2) begin
      check("slow_fast_edge", 32'(rq1[0]), 32'h81);
      check("slow_slow_edge", 32'(rq1[1]), 32'h81);
    end
    check("slow_ferr", 32'(ecnt1), 32'd0);

    check("rand_count", 32'(rq0.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rq0.size(); i++) begin
      check($sformatf("rand_byte%0d", i), 32'(rq0[i]), 32'(exp_q[i]));
    end
    check("rand_ferr", 32'(ecnt0 - e_before), 32'd0);
    check("ready_with_err", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/serial_byte_receiver.md
Name: serial_byte_receiver

Overview:
- Asynchronous 8N1 serial receiver that deserialises the RxD line into bytes.
- Sits directly upstream of the R/C servo pulse generator, which latches `RxD_data` whenever `RxD_data_ready` pulses.
- Line is oversampled from a tick generator derived from the system clock. Each bit is sampled at its midpoint. Framing errors and false starts are rejected.

Parameters:
- CLK_FREQ, 25000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- OVERSAMPLE, 8, oversample ticks per bit; must be an even number, at least 4.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE) (integer division), clocks per oversample tick; must be at least 2. The default evaluates to 27, giving a 216-clock bit period.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- RxD  input  1  raw serial line; idles high; asynchronous to clk.
- RxD_data_ready  output  1  one-clock pulse when a valid byte lands in RxD_data.
- RxD_data  output  8  last correctly received byte; held between frames.
- RxD_frame_error  output  1  one-clock pulse when the stop bit samples low.
- RxD_idle  output  1  high while the state is IDLE.

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock, `clk`; reset is asynchronous and active-low, `rst_n`.
  - While rst_n=0: RxD_data=8'h00, RxD_data_ready=0, RxD_frame_error=0, RxD_idle=1, state=IDLE.
  - Synchroniser flops reset to 1; all counters reset to 0.
  - Release takes effect on the next clk edge.
- Input path:
  - 2-flop synchroniser on RxD. All decisions use the second flop ("rx_s").
  - Latency from a pin change to rx_s is 2 clocks.
- Tick generator:
  - Counter 0..DIV-1; tick asserts for one clock when the count reaches DIV-1, then the counter wraps to 0.
  - Counter is held at 0 in IDLE and restarts from 0 on leaving IDLE. This aligns ticks to the detected start edge.
- State machine (IDLE, START, DATA, STOP, BREAK):
  - IDLE: on rx_s=0, go to START and clear the tick-in-bit counter.
  - START: after OVERSAMPLE/2 ticks (mid start bit), sample rx_s.
    - rx_s=0: go to DATA with bit index 0 and clear the tick-in-bit counter.
    - rx_s=1: false start; return to IDLE. No outputs change.
  - DATA: every OVERSAMPLE ticks, sample rx_s into shift register bit[index], LSB first.
    - After index 7 is sampled, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - rx_s=1: RxD_data <= shift register, RxD_data_ready=1 for exactly one clock (the clock after the sample edge), then IDLE.
    - rx_s=0: RxD_frame_error=1 for one clock, RxD_data unchanged, go to BREAK.
  - BREAK: wait until rx_s=1, then IDLE. This prevents a held-low line from being read as repeated frames.
- Timing and ordering:
  - Ready is never asserted together with frame_error.
  - Total frame latency: a start falling edge on the pin produces RxD_data_ready about 9.5 bit periods + 3 clocks later.
  - Back-to-back frames (stop bit immediately followed by the next start bit) must be received without loss. IDLE is re-entered at mid stop bit, well before the next start edge.
  - RxD changes while not in IDLE are ignored except at sample points.
- Reset mid-frame: immediate return to IDLE and reset values. The partial byte is discarded, and no ready or error pulse is emitted.

Test Plan:
- Defaults, 216 clk/bit, send 8'h55 (start, 1,0,1,0,1,0,1,0 LSB-first, stop) -> one RxD_data_ready pulse; RxD_data=8'h55; frame_error never asserted.
- Back-to-back frames 8'hA5, 8'h00, 8'hFF with no idle gap -> three ready pulses ~2160 clocks apart, with data A5, 00, FF in order.
- Glitch: RxD low for 50 clocks, then high -> state returns to IDLE; no ready, no error; RxD_data unchanged.
- Stop bit driven low after data 8'h3C, line held low a further 1000 clocks -> single frame_error pulse; RxD_data keeps its previous value; RxD_idle=0 until the line rises. A following 8'h12 is then received correctly.
- Assert rst_n=0 during DATA bit 4 of 8'hC3, release, then send 8'h7E -> no pulse for the aborted frame; RxD_data=8'h00 after reset, then 8'h7E.
- BAUD=9600 (DIV=325), send 8'h81 at ±2% baud error -> correct byte received at both extremes.
